// File: rtl/syn_fifo_pkg.sv
// syn_fifo_pkg: width helpers and configuration checks shared by the syn_fifo_param files.
package syn_fifo_pkg;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit cfg_ok(input int depth, input int width, input int af, input int ae);
        return (width >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/syn_fifo_ptr.sv
// syn_fifo_ptr: wrap-bit pointer counter; the MSB toggles each pass through the array.
module syn_fifo_ptr #(
    parameter int pw = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [pw-1:0] ptr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= '0;
        else if (inc) ptr <= ptr + pw'(1);
    end

endmodule

// File: rtl/syn_fifo_param.sv
// syn_fifo_param: parametrised single-clock FIFO with count, threshold and sticky error flags.
// SYN_FIFO_FWFT_EN selects first-word-fall-through reads instead of the registered read.
module syn_fifo_param
    import syn_fifo_pkg::*;
#(
    parameter int d_width   = 8,
    parameter int d_depth   = 8,
    parameter int af_thresh = d_depth - 2,
    parameter int ae_thresh = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [d_width-1:0]         w_data,
    input  logic                       w_en,
    input  logic                       r_en,
    input  logic                       err_clr,
    output logic [d_width-1:0]         r_data,
    output logic                       r_valid,
    output logic                       isEmpty,
    output logic                       isFull,
    output logic                       isAlmostFull,
    output logic                       isAlmostEmpty,
    output logic [$clog2(d_depth):0]   count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int aw = addr_w(d_depth);
    localparam int pw = ptr_w(d_depth);
    localparam logic [pw-1:0] af = pw'(af_thresh);
    localparam logic [pw-1:0] ae = pw'(ae_thresh);

    if (!cfg_ok(d_depth, d_width, af_thresh, ae_thresh)) begin : g_cfg_err
        $error("syn_fifo_param: invalid depth/width/threshold configuration");
    end

    logic [d_width-1:0] mem [d_depth];
    logic [pw-1:0]      w_ptr, r_ptr;
    logic               w_acc, r_acc;

    assign isEmpty       = w_ptr == r_ptr;
    assign isFull        = (w_ptr[aw-1:0] == r_ptr[aw-1:0]) && (w_ptr[aw] != r_ptr[aw]);
    assign count         = w_ptr - r_ptr;
    assign isAlmostFull  = count >= af;
    assign isAlmostEmpty = count <= ae;
    assign w_acc         = w_en && !isFull;
    assign r_acc         = r_en && !isEmpty;

    syn_fifo_ptr #(.pw(pw)) u_w_ptr (.clk(clk), .rst(rst), .inc(w_acc), .ptr(w_ptr));
    syn_fifo_ptr #(.pw(pw)) u_r_ptr (.clk(clk), .rst(rst), .inc(r_acc), .ptr(r_ptr));

    always_ff @(posedge clk) begin
        if (w_acc) mem[w_ptr[aw-1:0]] <= w_data;
    end

    // a new error in the same cycle as err_clr keeps the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (w_en && isFull) || (overflow && !err_clr);
            underflow <= (r_en && isEmpty) || (underflow && !err_clr);
        end
    end

`ifdef SYN_FIFO_FWFT_EN
    assign r_data  = mem[r_ptr[aw-1:0]];
    assign r_valid = !isEmpty;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_acc;
            if (r_acc) r_data <= mem[r_ptr[aw-1:0]];
        end
    end
`endif

endmodule

// File: tb/tb_syn_fifo_param.sv
// tb_syn_fifo_param: directed self-checking bench for syn_fifo_param (8x8, af=6, ae=2).
module tb_syn_fifo_param;

    logic       clk = 1'b0;
    logic       rst, w_en, r_en, err_clr;
    logic [7:0] w_data, r_data;
    logic       r_valid, isEmpty, isFull, isAlmostFull, isAlmostEmpty, overflow, underflow;
    logic [3:0] count;
    int         n_chk = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    syn_fifo_param #(.d_width(8), .d_depth(8), .af_thresh(6), .ae_thresh(2)) dut (
        .clk(clk), .rst(rst), .w_data(w_data), .w_en(w_en), .r_en(r_en), .err_clr(err_clr),
        .r_data(r_data), .r_valid(r_valid), .isEmpty(isEmpty), .isFull(isFull),
        .isAlmostFull(isAlmostFull), .isAlmostEmpty(isAlmostEmpty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0; w_data = 8'h00;
        step();
        step();
        chk("rst_count", count, 0);
        chk("rst_empty", isEmpty, 1);
        chk("rst_full", isFull, 0);
        chk("rst_ae", isAlmostEmpty, 1);
        chk("rst_af", isAlmostFull, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
`ifndef SYN_FIFO_FWFT_EN
        chk("rst_rvalid", r_valid, 0);
        chk("rst_rdata", r_data, 0);
`endif
        rst = 1'b0;
`ifdef SYN_FIFO_FWFT_EN
        w_data = 8'hA5; w_en = 1'b1;
        step();
        w_en = 1'b0;
        chk("fwft_valid", r_valid, 1);
        chk("fwft_data", r_data, 8'hA5);
        chk("fwft_count", count, 1);
        step();
        chk("fwft_hold", r_data, 8'hA5);
        r_en = 1'b1;
        step();
        r_en = 1'b0;
        chk("fwft_empty", isEmpty, 1);
        chk("fwft_novalid", r_valid, 0);
        chk("fwft_unf", underflow, 0);
`else
        // fill, overflow attempt, then drain in order
        for (int i = 1; i <= 8; i++) begin
            w_data = 8'(i); w_en = 1'b1;
            step();
            chk("fill_count", count, i);
            chk("fill_af", isAlmostFull, i >= 6);
            chk("fill_ae", isAlmostEmpty, i <= 2);
            chk("fill_full", isFull, i == 8);
        end
        w_data = 8'hFF;
        step();
        w_en = 1'b0;
        chk("ovf_count", count, 8);
        chk("ovf_set", overflow, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("ovf_clr", overflow, 0);
        for (int i = 1; i <= 8; i++) begin
            r_en = 1'b1;
            step();
            chk("drain_valid", r_valid, 1);
            chk("drain_data", r_data, i);
            chk("drain_count", count, 8 - i);
        end
        r_en = 1'b0;
        step();
        chk("drain_novalid", r_valid, 0);
        chk("drain_hold", r_data, 8);
        chk("drain_empty", isEmpty, 1);
        chk("drain_unf", underflow, 0);
        // three full rounds so both pointers wrap repeatedly
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 8; k++) begin
                w_data = 8'(8'h20 + r * 8 + k); w_en = 1'b1;
                step();
                chk("wrap_nempty", isEmpty, 0);
                chk("wrap_full", isFull, k == 7);
            end
            w_en = 1'b0;
            for (int k = 0; k < 8; k++) begin
                r_en = 1'b1;
                step();
                chk("wrap_data", r_data, 8'h20 + r * 8 + k);
                chk("wrap_nfull", isFull, 0);
            end
            r_en = 1'b0;
            chk("wrap_empty", isEmpty, 1);
        end
        // simultaneous read/write while full
        for (int k = 0; k < 8; k++) begin
            w_data = 8'(8'h10 + k); w_en = 1'b1;
            step();
        end
        chk("sim_full", isFull, 1);
        w_data = 8'hEE; r_en = 1'b1;
        step();
        chk("sim_full_count", count, 7);
        chk("sim_full_ovf", overflow, 1);
        chk("sim_full_data", r_data, 8'h10);
        w_data = 8'hEF;
        step();
        w_en = 1'b0;
        chk("sim_both_count", count, 7);
        chk("sim_both_data", r_data, 8'h11);
        for (int k = 0; k < 7; k++) begin
            step();
            chk("sim_drain", r_data, k < 6 ? 8'h12 + k : 8'hEF);
        end
        r_en = 1'b0; err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("sim_empty", isEmpty, 1);
        chk("sim_ovf_clr", overflow, 0);
        // reads on empty
        r_en = 1'b1;
        step();
        chk("unf_set", underflow, 1);
        chk("unf_novalid", r_valid, 0);
        chk("unf_hold", r_data, 8'hEF);
        r_en = 1'b0; err_clr = 1'b1;
        step();
        chk("unf_clr", underflow, 0);
        r_en = 1'b1;
        step();
        chk("unf_set_wins", underflow, 1);
        err_clr = 1'b0; w_en = 1'b1; w_data = 8'h33;
        step();
        chk("sim_empty_count", count, 1);
        chk("sim_empty_novalid", r_valid, 0);
        chk("sim_empty_unf", underflow, 1);
        r_en = 1'b0;
        for (int k = 0; k < 4; k++) step();
        w_en = 1'b0;
        chk("pre_rst_count", count, 5);
        // asynchronous reset away from the clock edge
        #2 rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", isEmpty, 1);
        chk("arst_rvalid", r_valid, 0);
        chk("arst_rdata", r_data, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_unf", underflow, 0);
        step();
        rst = 1'b0;
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/syn_fifo_param.md
Name: syn_fifo_param

Overview:
- Parametrised successor to the team's 8x8 synchronous FIFO.
- Single clock domain FIFO; any power-of-two depth; any data width.
- Adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a read-data valid strobe.
- Sits between producer/consumer blocks in the same clock domain as the general-purpose buffering primitive.

Parameters:
- d_width, 8, data word width in bits (>=1).
- d_depth, 8, number of entries; must be a power of two, >=2.
- af_thresh, d_depth-2, isAlmostFull asserts when count >= af_thresh (1..d_depth).
- ae_thresh, 2, isAlmostEmpty asserts when count <= ae_thresh (0..d_depth-1).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- w_data  input  d_width  write data.
- w_en  input  1  write request.
- r_en  input  1  read request.
- err_clr  input  1  synchronous clear of overflow/underflow flags.
- r_data  output  d_width  read data.
- r_valid  output  1  r_data holds a newly read word this cycle.
- isEmpty  output  1  count == 0.
- isFull  output  1  count == d_depth.
- isAlmostFull  output  1  count >= af_thresh.
- isAlmostEmpty  output  1  count <= ae_thresh.
- count  output  $clog2(d_depth)+1  current occupancy.
- overflow  output  1  sticky: write attempted while full.
- underflow  output  1  sticky: read attempted while empty.

Behaviour:
- Reset is asynchronous and active-high: rst=1 immediately clears state. After reset: w_ptr=r_ptr=0, count=0, isEmpty=1, isFull=0, isAlmostEmpty=1, isAlmostFull=0 (given af_thresh>=1), r_data=0, r_valid=0, overflow=underflow=0. Storage array is not reset.
- Pointers: each is AW+1 bits, AW=$clog2(d_depth). Low AW bits address the array; the MSB is the wrap bit. Increments wrap naturally modulo 2*d_depth. No depth-specific bit slicing.
- Flags are combinational from registered pointers:
  - isEmpty: pointers equal.
  - isFull: address bits equal, wrap bits differ.
  - count = w_ptr - r_ptr, width AW+1.
- Write accepted iff w_en && !isFull. On acceptance: mem[w_ptr[AW-1:0]] <= w_data; w_ptr++.
- Read accepted iff r_en && !isEmpty. On acceptance: r_data <= mem[r_ptr]; r_ptr++; r_valid=1 next cycle. Latency is 1 cycle from accepted r_en to r_valid/r_data.
- r_valid is 0 in any cycle following a non-accepted read. r_data holds its last value when no read is accepted.
- Simultaneous w_en and r_en:
  - Neither full nor empty: both accepted, count unchanged.
  - Empty: write only; r_en is rejected and sets underflow.
  - Full: read only; w_en is rejected and sets overflow. The freed slot is usable next cycle.
- overflow sets on w_en && isFull; underflow sets on r_en && isEmpty. Both hold until err_clr=1 or reset. If err_clr and a new error occur in the same cycle, the set wins.
- Rejected operations never modify pointers or memory.

Optional Feature:
- Macro SYN_FIFO_FWFT_EN selects first-word-fall-through mode.
- Defined (FWFT): r_data = mem[r_ptr] combinationally, r_valid = !isEmpty. The head word is visible with zero latency; r_en acknowledges it and advances r_ptr. r_data is undefined while r_valid=0.
- Undefined: the standard 1-cycle registered read described above.

Decomposition:
- Package syn_fifo_pkg holds:
  - function addr_w(depth) = $clog2(depth);
  - localparam-style helpers for pointer width;
  - elaboration check that d_depth is a power of two and that thresholds are in range.
- One sub-module is natural: syn_fifo_ptr, a wrap-bit pointer counter with increment enable and async active-high reset. It is instantiated twice, for write and read.

Test Plan (d_width=8, d_depth=8, af_thresh=6, ae_thresh=2, standard mode unless noted):
- Reset: rst=1 mid-operation with 5 entries -> immediately count=0, isEmpty=1, r_valid=0, r_data=0, overflow=0.
- Fill: write 0x01..0x08 -> count 1..8; isAlmostFull from count=6; isFull at 8; 9th write 0xFF rejected, overflow=1; 8 reads return 0x01..0x08, each r_valid one cycle after its r_en.
- Wrap: 3 cycles of {write 8, read 8} -> pointers wrap twice; data stays in order; no full/empty false flags.
- Simultaneous at full: count=8, w_en=r_en=1 -> read accepted, write rejected, count=7, overflow=1. Next cycle w_en=r_en=1 -> both accepted, count stays 7.
- Empty read: r_en on empty -> underflow=1, r_valid=0, r_data unchanged. err_clr=1 -> underflow=0. err_clr plus a new empty read -> underflow stays 1.
- FWFT (SYN_FIFO_FWFT_EN): write 0xA5 into empty -> next cycle r_valid=1 and r_data=0xA5 without r_en; r_en=1 -> isEmpty=1 next cycle.
